// File: rtl/alt_cal_seq_sim.sv
// alt_cal_seq_sim: sequences offset calibration over every transceiver channel via DPRIO writes
module alt_cal_seq_sim #(
    parameter int NUMBER_OF_CHANNELS = 4,
    parameter int CHANNEL_ADDRESS_WIDTH = 2,
    parameter int CAL_CYCLES = 15,
    parameter int COUNTER_WIDTH = 8,
    parameter int AUTO_RUN = 1,
    parameter int CHECK_TESTBUS = 0,
    parameter logic [NUMBER_OF_CHANNELS-1:0] ERROR_MASK = '0,
    parameter logic [13:0] CAL_REG_ADDR = 14'h0021
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUMBER_OF_CHANNELS-1:0]    testbuses,
    input  logic                             dprio_busy,
    input  logic [15:0]                      dprio_datain,
    output logic                             busy,
    output logic                             cal_done,
    output logic [NUMBER_OF_CHANNELS-1:0]    cal_error,
    output logic [15:0]                      dprio_addr,
    output logic [15:0]                      dprio_dataout,
    output logic                             dprio_wren,
    output logic                             dprio_rden,
    output logic [8:0]                       quad_addr,
    output logic [CHANNEL_ADDRESS_WIDTH-1:0] cur_channel
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT, S_CHECK, S_DONE} state_t;
    state_t state, state_d;
    logic [CHANNEL_ADDRESS_WIDTH-1:0] ch, ch_d;
    logic [COUNTER_WIDTH-1:0] cnt, cnt_d;
    logic [NUMBER_OF_CHANNELS-1:0] err_d, sel, bad;
    logic start_q, auto_pending, auto_d, wr_fire, in_write, in_chan;
    logic [7:0] ch_ext;
    logic unused_datain;
    assign unused_datain = ^dprio_datain;
    assign sel = NUMBER_OF_CHANNELS'(1) << ch;
    assign bad = (CHECK_TESTBUS != 0) ? ~testbuses : ERROR_MASK;
    assign ch_ext = 8'(ch);
    assign in_write = state == S_WRITE;
    assign in_chan = in_write || state == S_WAIT || state == S_CHECK;
    assign dprio_wren = wr_fire & ~reset;
    assign dprio_rden = 1'b0;
    assign dprio_addr = in_write ? {ch_ext[1:0], CAL_REG_ADDR} : 16'h0;
    assign dprio_dataout = in_write ? 16'h0001 : 16'h0;
    assign quad_addr = in_write ? {1'b0, ch_ext >> 2} : 9'h0;
    assign cur_channel = in_chan ? ch : '0;
    // Register the sequencer state, datapath and the registered status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            ch <= '0;
            cnt <= '0;
            start_q <= 1'b0;
            auto_pending <= (AUTO_RUN != 0);
            cal_error <= '0;
            busy <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            state <= state_d;
            ch <= ch_d;
            cnt <= cnt_d;
            start_q <= start;
            auto_pending <= auto_d;
            cal_error <= err_d;
            busy <= state_d != S_IDLE;
            cal_done <= state_d == S_DONE;
        end
    end
    // Next-state and datapath updates for the per-channel write/wait/check loop
    always_comb begin
        state_d = state;
        ch_d = ch;
        cnt_d = cnt;
        err_d = cal_error;
        auto_d = auto_pending;
        wr_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (auto_pending || (start && !start_q)) begin
                    state_d = S_WRITE;
                    ch_d = '0;
                    err_d = '0;
                    auto_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (!dprio_busy) begin
                    wr_fire = 1'b1;
                    cnt_d = COUNTER_WIDTH'(CAL_CYCLES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) state_d = S_CHECK;
                else cnt_d = cnt - COUNTER_WIDTH'(1);
            end
            S_CHECK: begin
                err_d = (cal_error & ~sel) | (bad & sel);
                if (ch == CHANNEL_ADDRESS_WIDTH'(NUMBER_OF_CHANNELS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d = ch + CHANNEL_ADDRESS_WIDTH'(1);
                    state_d = S_WRITE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_alt_cal_seq_sim.sv
// tb_alt_cal_seq_sim: randomized and directed checks of the calibration sequencer against a run-level model
module tb_alt_cal_seq_sim;
    localparam int N = 4;
    localparam int CAL = 15;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, dprio_busy = 1'b0;
    logic [3:0] testbuses = 4'hF;
    logic [15:0] dprio_datain = 16'h0;
    logic busy, cal_done, dprio_wren, dprio_rden;
    logic [3:0] cal_error;
    logic [15:0] dprio_addr, dprio_dataout;
    logic [8:0] quad_addr;
    logic [1:0] cur_channel;
    logic r1 = 1'b1, tb1 = 1'b1;
    logic b1, d1, w1, rd1;
    logic [0:0] e1, c1;
    logic [15:0] a1, do1;
    logic [8:0] q1;
    int pass_cnt = 0, total_cnt = 0;

    always #5 clock = ~clock;

    alt_cal_seq_sim #(.NUMBER_OF_CHANNELS(4), .CHANNEL_ADDRESS_WIDTH(2), .CAL_CYCLES(15),
        .COUNTER_WIDTH(8), .AUTO_RUN(1), .CHECK_TESTBUS(1)) dut (
        .clock(clock), .reset(reset), .start(start), .testbuses(testbuses),
        .dprio_busy(dprio_busy), .dprio_datain(dprio_datain), .busy(busy), .cal_done(cal_done),
        .cal_error(cal_error), .dprio_addr(dprio_addr), .dprio_dataout(dprio_dataout),
        .dprio_wren(dprio_wren), .dprio_rden(dprio_rden), .quad_addr(quad_addr),
        .cur_channel(cur_channel));

    alt_cal_seq_sim #(.NUMBER_OF_CHANNELS(1), .CHANNEL_ADDRESS_WIDTH(1), .CAL_CYCLES(1),
        .COUNTER_WIDTH(8), .AUTO_RUN(1), .CHECK_TESTBUS(0), .ERROR_MASK(1'b1)) dut1 (
        .clock(clock), .reset(r1), .start(1'b0), .testbuses(tb1),
        .dprio_busy(1'b0), .dprio_datain(16'h0), .busy(b1), .cal_done(d1),
        .cal_error(e1), .dprio_addr(a1), .dprio_dataout(do1),
        .dprio_wren(w1), .dprio_rden(rd1), .quad_addr(q1), .cur_channel(c1));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Run-level model: a run is a list of channel slots (write slot, CAL wait cycles, check), then a done cycle
    bit m_run = 0, m_done = 0, m_auto = 1, m_prev = 0, m_rise;
    int m_ch = 0, m_pos = 0;
    logic [3:0] m_err = 4'h0;
    always @(posedge clock) begin
        if (reset) begin
            m_run = 0; m_done = 0; m_auto = 1; m_prev = 0; m_ch = 0; m_pos = 0; m_err = 4'h0;
        end else begin
            m_rise = start && !m_prev;
            m_prev = start;
            if (m_done) m_done = 0;
            else if (!m_run) begin
                if (m_auto || m_rise) begin
                    m_run = 1; m_ch = 0; m_pos = 0; m_err = 4'h0; m_auto = 0;
                end
            end else if (m_pos == 0) begin
                if (!dprio_busy) m_pos = 1;
            end else if (m_pos <= CAL) m_pos++;
            else begin
                m_err[m_ch] = ~testbuses[m_ch];
                if (m_ch == N - 1) begin m_run = 0; m_done = 1; end
                else begin m_ch++; m_pos = 0; end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    bit chk_en = 0, e_in_w;
    logic [50:0] exp_v, act_v;
    always @(negedge clock) begin
        if (chk_en) begin
            e_in_w = m_run && m_pos == 0;
            exp_v = {m_run || m_done, m_done, e_in_w && !dprio_busy && !reset, 1'b0, m_err,
                     e_in_w ? {2'(m_ch), 14'h0021} : 16'h0, e_in_w ? 16'h0001 : 16'h0,
                     e_in_w ? 9'(m_ch / 4) : 9'h0, m_run ? 2'(m_ch) : 2'b00};
            act_v = {busy, cal_done, dprio_wren, dprio_rden, cal_error, dprio_addr,
                     dprio_dataout, quad_addr, cur_channel};
            check("cycle", 64'(act_v), 64'(exp_v));
        end
    end

    // Per-run statistics gathered from the DUT outputs for the directed checks
    bit prev_busy = 0;
    int cur_len = 0, last_len = 0, done_cnt = 0, run_cnt = 0, wren_total = 0;
    logic [3:0] last_err;
    logic [15:0] wq[$], wpos[$], last_wq[$], last_wpos[$];
    always @(negedge clock) begin
        if (busy && !prev_busy) begin cur_len = 0; wq.delete(); wpos.delete(); run_cnt++; end
        if (busy) cur_len++;
        if (dprio_wren) begin wq.push_back(dprio_addr); wpos.push_back(16'(cur_len)); wren_total++; end
        if (cal_done) begin last_len = cur_len; last_err = cal_error; last_wq = wq; last_wpos = wpos; done_cnt++; end
        prev_busy = busy;
    end

    function automatic logic [63:0] pk(input logic [15:0] q[$]);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[47:0], (i < q.size()) ? q[i] : 16'hFFFF};
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < lim) begin @(posedge clock); i++; end
        #1;
        check(nm, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_for(input logic [1:0] c, input logic wr, input string nm);
        int i = 0;
        while (!(busy && cur_channel == c && (dprio_dataout == 16'h1) == wr) && i < 200) begin step(1); i++; end
        check(nm, 64'(i < 200), 64'd1);
    endtask

    int rc, wt, nb, nd, nw;
    logic [15:0] aw;
    logic [8:0] qor;
    logic ed;
    initial begin
        @(posedge clock); #1;
        chk_en = 1;
        @(negedge clock);
        check("reset_state", {busy, cal_done, dprio_wren, cur_channel, cal_error, dprio_addr}, 0);
        step(2);
        reset = 1'b0;
        wait_done(200, "t1_timeout");
        check("t1_len", last_len, 69);
        check("t1_addr", pk(last_wq), 64'h0021_4021_8021_C021);
        check("t1_wpos", pk(last_wpos), {16'd1, 16'd18, 16'd35, 16'd52});
        check("t1_ndone", done_cnt, 1);
        check("t1_err", last_err, 4'h0);
        pulse_start();
        wait_for(2'd2, 1'b1, "t2_sync");
        dprio_busy = 1'b1;
        step(5);
        dprio_busy = 1'b0;
        wait_done(200, "t2_timeout");
        check("t2_len", last_len, 74);
        check("t2_wpos", pk(last_wpos), {16'd1, 16'd18, 16'd40, 16'd57});
        check("t2_addr", pk(last_wq), 64'h0021_4021_8021_C021);
        testbuses = 4'b1011;
        pulse_start();
        wait_done(200, "t3_timeout");
        check("t3_err", last_err, 4'b0100);
        step(3);
        check("t3_hold", cal_error, 4'b0100);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t3_clear", {busy, cal_error}, {1'b1, 4'b0000});
        @(posedge clock); #1;
        start = 1'b0;
        testbuses = 4'hF;
        wait_done(200, "t3b_timeout");
        pulse_start();
        step(20);
        pulse_start();
        wait_done(200, "t4_timeout");
        rc = run_cnt;
        step(40);
        check("t4_midstart", run_cnt - rc, 0);
        start = 1'b1;
        rc = run_cnt;
        step(200);
        check("t4_held", run_cnt - rc, 1);
        start = 1'b0;
        step(2);
        pulse_start();
        wait_for(2'd1, 1'b0, "t5_sync");
        step(2);
        reset = 1'b1;
        wt = wren_total;
        @(posedge clock);
        @(negedge clock);
        check("t5_zero", {busy, cal_done, dprio_wren, dprio_addr, dprio_dataout, quad_addr, cur_channel, cal_error}, 0);
        step(3);
        check("t5_nowren", wren_total - wt, 0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("t5_restart", {busy, cur_channel}, {1'b1, 2'd0});
        @(posedge clock); #1;
        wait_done(200, "t5_timeout");
        check("t5_len", last_len, 69);
        for (int i = 0; i < 3000; i++) begin
            dprio_busy = ($urandom_range(0, 3) == 0);
            testbuses = 4'($urandom);
            if ($urandom_range(0, 40) == 0) start = ~start;
            reset = ($urandom_range(0, 600) == 0);
            step(1);
        end
        reset = 1'b0;
        start = 1'b0;
        dprio_busy = 1'b0;
        step(120);
        r1 = 1'b0;
        nb = 0; nd = 0; nw = 0; aw = 16'hFFFF; qor = '0; ed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            nb += int'(b1);
            if (d1) begin nd++; ed = e1[0]; end
            if (w1) begin nw++; aw = a1; end
            qor |= q1;
        end
        check("t6_busy", nb, 4);
        check("t6_done", nd, 1);
        check("t6_err", ed, 1'b1);
        check("t6_wren", nw, 1);
        check("t6_addr", aw, 16'h0021);
        check("t6_quad", qor, 9'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
